// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_rr_arbiter
//  Purpose  : Round-robin arbiter with one-hot grant, binary index and a
//             valid/ready downstream handshake. A presented grant is locked
//             until it is accepted, so later requests cannot disturb it.
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_rr_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    localparam logic [0:0]           ST_IDLE    = 1'b0;
    localparam logic [0:0]           ST_LOCKED  = 1'b1;
    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

    logic [0:0]           r_state;
    logic [IDX_WIDTH-1:0] r_prio;
    logic [NUM_REQ-1:0]   r_gnt;

    logic [NUM_REQ-1:0]   w_mask;
    logic [NUM_REQ-1:0]   w_pick_src;
    logic [NUM_REQ-1:0]   w_rr_gnt;
    logic                 w_found;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [IDX_WIDTH-1:0] w_idx;
    logic [IDX_WIDTH-1:0] w_prio_next;
    logic                 w_valid;
    logic                 w_handshake;

    // Round-robin pick: lowest request at or above the pointer, else lowest overall (wrap).
    always_comb begin
        w_mask   = '0;
        w_rr_gnt = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (IDX_WIDTH'(i) >= r_prio);
        end
        w_pick_src = (|(req_i & w_mask)) ? (req_i & w_mask) : req_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_pick_src[i]) begin
                w_rr_gnt[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    // Select live or locked grant and encode its binary index.
    always_comb begin
        w_valid = (r_state == ST_LOCKED) ? 1'b1  : (|req_i);
        w_gnt   = (r_state == ST_LOCKED) ? r_gnt : w_rr_gnt;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_idx = w_idx | IDX_WIDTH'(i);
            end
        end
        w_handshake = w_valid & ready_i;
        w_prio_next = (w_idx == c_LAST_IDX) ? '0 : (w_idx + IDX_WIDTH'(1));
    end

    assign valid_o     = w_valid;
    assign gnt_o       = w_gnt;
    assign idx_o       = w_idx;
    assign req_ready_o = w_gnt & {NUM_REQ{ready_i}};

    // Lock an unaccepted grant, release on handshake, advance the pointer past the winner.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_prio  <= '0;
            r_gnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid && !ready_i) begin
                        r_state <= ST_LOCKED;
                        r_gnt   <= w_gnt;
                    end
                end
                default: begin
                    if (ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
            if (w_handshake) begin
                r_prio <= w_prio_next;
            end
        end
    end

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
    // A locked requester must keep requesting until it has been accepted.
    a_locked_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == ST_LOCKED) |-> (|(req_i & r_gnt)));

    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(w_gnt));
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_rr_arbiter
//  Purpose  : Directed self-checking bench for onehot_rr_arbiter
//             (NUM_REQ = 4, 5 and 1 instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_rr_arbiter;

    logic       clk;
    logic       rst_n;

    logic [3:0] req4, rr4, gnt4;
    logic       ready4, valid4;
    logic [1:0] idx4;

    logic [4:0] req5, rr5, gnt5;
    logic       ready5, valid5;
    logic [2:0] idx5;

    logic [0:0] req1, rr1, gnt1;
    logic       ready1, valid1;
    logic [0:0] idx1;

    int n_tests;
    int n_fail;

    onehot_rr_arbiter #(.NUM_REQ(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req4), .req_ready_o(rr4),
        .valid_o(valid4), .ready_i(ready4), .gnt_o(gnt4), .idx_o(idx4)
    );

    onehot_rr_arbiter #(.NUM_REQ(5)) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req5), .req_ready_o(rr5),
        .valid_o(valid5), .ready_i(ready5), .gnt_o(gnt5), .idx_o(idx5)
    );

    onehot_rr_arbiter #(.NUM_REQ(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .req_ready_o(rr1),
        .valid_o(valid1), .ready_i(ready1), .gnt_o(gnt1), .idx_o(idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic do_reset();
        rst_n  = 1'b0;
        req4   = '0; ready4 = 1'b0;
        req5   = '0; ready5 = 1'b0;
        req1   = '0; ready1 = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid4); end
        n_tests++; if (gnt4 !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt4); end
        n_tests++; if (idx4 !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", idx4); end
        n_tests++; if (rr4 !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", rr4); end
        n_tests++; if (gnt5 !== 5'b00000) begin n_fail++; $display("FAIL reset_gnt5: got %b expected 00000", gnt5); end
        next_cycle();
    endtask

    task automatic test_rotate();
        logic [3:0] exp_gnt [5];
        logic [1:0] exp_idx [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req4   = 4'b1111;
        ready4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++; if (gnt4 !== exp_gnt[k]) begin n_fail++; $display("FAIL rotate_gnt[%0d]: got %b expected %b", k, gnt4, exp_gnt[k]); end
            n_tests++; if (idx4 !== exp_idx[k]) begin n_fail++; $display("FAIL rotate_idx[%0d]: got %0d expected %0d", k, idx4, exp_idx[k]); end
            n_tests++; if (rr4 !== exp_gnt[k]) begin n_fail++; $display("FAIL rotate_req_ready[%0d]: got %b expected %b", k, rr4, exp_gnt[k]); end
            next_cycle();
        end
        // Pointer is now 1 (last winner was index 0).
    endtask

    task automatic test_req_zero();
        req4 = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            ready4 = (k == 0);
            @(negedge clk);
            n_tests++; if (valid4 !== 1'b0) begin n_fail++; $display("FAIL zero_valid[%0d]: got %b expected 0", k, valid4); end
            n_tests++; if (gnt4 !== 4'b0000) begin n_fail++; $display("FAIL zero_gnt[%0d]: got %b expected 0000", k, gnt4); end
            n_tests++; if (idx4 !== 2'd0) begin n_fail++; $display("FAIL zero_idx[%0d]: got %0d expected 0", k, idx4); end
            n_tests++; if (rr4 !== 4'b0000) begin n_fail++; $display("FAIL zero_req_ready[%0d]: got %b expected 0000", k, rr4); end
            next_cycle();
        end
        // Pointer must still be 1: all requesting picks index 1.
        req4   = 4'b1111;
        ready4 = 1'b1;
        @(negedge clk);
        n_tests++; if (gnt4 !== 4'b0010) begin n_fail++; $display("FAIL zero_prio_kept: got %b expected 0010", gnt4); end
        next_cycle();
    endtask

    task automatic test_lock_hold();
        do_reset();
        req4   = 4'b0110;
        ready4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) req4 = 4'b0111;
            @(negedge clk);
            n_tests++; if (gnt4 !== 4'b0010) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b expected 0010", k, gnt4); end
            n_tests++; if (idx4 !== 2'd1) begin n_fail++; $display("FAIL lock_idx[%0d]: got %0d expected 1", k, idx4); end
            n_tests++; if (valid4 !== 1'b1) begin n_fail++; $display("FAIL lock_valid[%0d]: got %b expected 1", k, valid4); end
            n_tests++; if (rr4 !== 4'b0000) begin n_fail++; $display("FAIL lock_req_ready[%0d]: got %b expected 0000", k, rr4); end
            next_cycle();
        end
        ready4 = 1'b1;
        @(negedge clk);
        n_tests++; if (rr4 !== 4'b0010) begin n_fail++; $display("FAIL lock_accept: got %b expected 0010", rr4); end
        next_cycle();
        // Requester 1 drops after acceptance; pointer is 2, so index 2 beats index 0.
        req4 = 4'b0101;
        @(negedge clk);
        n_tests++; if (gnt4 !== 4'b0100) begin n_fail++; $display("FAIL lock_next_gnt: got %b expected 0100", gnt4); end
        n_tests++; if (idx4 !== 2'd2) begin n_fail++; $display("FAIL lock_next_idx: got %0d expected 2", idx4); end
        next_cycle();
    endtask

    task automatic test_reset_locked();
        do_reset();
        req4   = 4'b0100;
        ready4 = 1'b0;
        next_cycle();
        req4 = 4'b1111;
        @(negedge clk);
        n_tests++; if (gnt4 !== 4'b0100) begin n_fail++; $display("FAIL rstlock_held: got %b expected 0100", gnt4); end
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (gnt4 !== 4'b0001) begin n_fail++; $display("FAIL rstlock_gnt: got %b expected 0001", gnt4); end
        n_tests++; if (valid4 !== 1'b1) begin n_fail++; $display("FAIL rstlock_valid: got %b expected 1", valid4); end
        n_tests++; if (idx4 !== 2'd0) begin n_fail++; $display("FAIL rstlock_idx: got %0d expected 0", idx4); end
        next_cycle();
    endtask

    task automatic test_wrap5();
        do_reset();
        req5   = 5'b01000;
        ready5 = 1'b1;
        @(negedge clk);
        n_tests++; if (idx5 !== 3'd3) begin n_fail++; $display("FAIL wrap5_setup_idx: got %0d expected 3", idx5); end
        next_cycle();
        req5 = 5'b10001;
        @(negedge clk);
        n_tests++; if (gnt5 !== 5'b10000) begin n_fail++; $display("FAIL wrap5_gnt: got %b expected 10000", gnt5); end
        n_tests++; if (idx5 !== 3'd4) begin n_fail++; $display("FAIL wrap5_idx: got %0d expected 4", idx5); end
        n_tests++; if (rr5 !== 5'b10000) begin n_fail++; $display("FAIL wrap5_req_ready: got %b expected 10000", rr5); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (gnt5 !== 5'b00001) begin n_fail++; $display("FAIL wrap5_after_gnt: got %b expected 00001", gnt5); end
        n_tests++; if (idx5 !== 3'd0) begin n_fail++; $display("FAIL wrap5_after_idx: got %0d expected 0", idx5); end
        next_cycle();
        req5 = '0;
    endtask

    task automatic test_single();
        do_reset();
        req1   = 1'b1;
        ready1 = 1'b1;
        @(negedge clk);
        n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b expected 1", gnt1); end
        n_tests++; if (rr1 !== 1'b1) begin n_fail++; $display("FAIL single_req_ready: got %b expected 1", rr1); end
        n_tests++; if (idx1 !== 1'b0) begin n_fail++; $display("FAIL single_idx: got %0d expected 0", idx1); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL single_gnt2: got %b expected 1", gnt1); end
        next_cycle();
        req1 = 1'b0;
        @(negedge clk);
        n_tests++; if (valid1 !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %b expected 0", valid1); end
        n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL single_idle_gnt: got %b expected 0", gnt1); end
        next_cycle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_rotate();
        test_req_zero();
        test_lock_hold();
        test_reset_locked();
        test_wrap5();
        test_single();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_rr_arbiter.md
ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 8, number of requesters (>=1).
REQ-002 The block SHALL have parameter IDX_WIDTH, default (NUM_REQ==1 ? 1 : $clog2(NUM_REQ)), binary index width; not to be overridden.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port req_i, input, NUM_REQ, per-requester request.
REQ-006 The block SHALL have port req_ready_o, output, NUM_REQ, per-requester acceptance strobe.
REQ-007 The block SHALL have port valid_o, output, 1, a grant is presented downstream.
REQ-008 The block SHALL have port ready_i, input, 1, downstream accepts the grant.
REQ-009 The block SHALL have port gnt_o, output, NUM_REQ, one-hot grant (all-zero when valid_o=0).
REQ-010 The block SHALL have port idx_o, output, IDX_WIDTH, binary index of the set gnt_o bit; 0 when gnt_o=0.

Function
REQ-011 The block SHALL hold a priority pointer prio_q (IDX_WIDTH bits, range 0..NUM_REQ-1).
REQ-012 The block SHALL hold a state register with states IDLE and LOCKED, plus a registered grant gnt_q.
REQ-013 In IDLE, gnt_o SHALL be combinational: the first set req_i bit scanning upward from index prio_q, wrapping from NUM_REQ-1 to 0.
REQ-014 In IDLE, valid_o SHALL equal |req_i, zero-latency.
REQ-015 In LOCKED, gnt_o SHALL equal gnt_q and valid_o SHALL be 1, independent of req_i.
REQ-016 gnt_o SHALL always satisfy $onehot0; idx_o SHALL be its one-hot-to-binary encoding.
REQ-017 Handshake SHALL be defined as valid_o & ready_i in the same cycle.
REQ-018 req_ready_o SHALL equal gnt_o AND-ed with the replicated ready_i, so exactly the granted requester sees acceptance on a handshake.
REQ-019 IDLE->LOCKED SHALL occur when valid_o=1 and ready_i=0; gnt_q captures gnt_o that cycle.
REQ-020 LOCKED->IDLE SHALL occur on a handshake; LOCKED otherwise persists.
REQ-021 On every handshake, prio_q SHALL be set to idx_o+1, wrapping to 0 when idx_o==NUM_REQ-1, including non-power-of-two NUM_REQ.
REQ-022 Without a handshake, prio_q SHALL be unchanged.
REQ-023 New requests arriving during LOCKED SHALL NOT alter gnt_o, idx_o or prio_q until the handshake.
REQ-024 A requester SHALL hold req_i until its req_ready_o pulse; deassertion of a locked requester SHALL trigger a simulation-only assertion; gnt_o stays held regardless.
REQ-025 With NUM_REQ=1, gnt_o SHALL equal req_i (or gnt_q), idx_o SHALL be 0 and prio_q SHALL stay 0.
REQ-026 Simulation-only assertions SHALL be excluded under SYNTHESIS or COMMON_CELLS_ASSERTS_OFF.

Reset
REQ-027 When rst_ni=0 at a clock edge, state SHALL become IDLE, prio_q 0, gnt_q 0, regardless of state (including mid-LOCKED).
REQ-028 After reset with req_i=0: valid_o=0, gnt_o=0, idx_o=0, req_ready_o=0.

Verification (NUM_REQ=4 unless noted)
REQ-029 Reset, req_i=4'b1111, ready_i=1 for 5 cycles -> gnt_o 0001,0010,0100,1000,0001; idx_o 0,1,2,3,0.
REQ-030 req_i=4'b0110, ready_i=0 for 3 cycles, req_i[0] raised in cycle 2 -> gnt_o=0010, idx_o=1 all 3 cycles; ready_i=1 -> req_ready_o=0010, next cycle gnt_o=0100 (prio_q=2).
REQ-031 NUM_REQ=5, prio_q=4, req_i=5'b10001, ready_i=1 -> gnt_o=10000, idx_o=4, then prio_q=0, gnt_o=00001.
REQ-032 LOCKED on gnt_o=0100, rst_ni=0 one cycle, req_i=1111 -> after reset gnt_o=0001, valid_o=1.
REQ-033 req_i=0 any ready_i -> valid_o=0, gnt_o=0, idx_o=0, req_ready_o=0, prio_q unchanged.
